// File: rtl/conv3_pkg.sv
// rtl/conv3_pkg.sv - shared types and engine geometry for the 3x3 convolution sequencer
package conv3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_NEXT
  } conv3_state_e;

  localparam int unsigned ENG_AW_DEF     = 14;
  localparam int unsigned KERNEL_NUM_DEF = 128;

  function automatic int unsigned ram_depth(input int unsigned kernel_num);
    return 2 * 9 * (kernel_num / 8);
  endfunction

  function automatic int unsigned output_point(input int unsigned kernel_num);
    return kernel_num / 64;
  endfunction

  localparam int unsigned RAM_DEPTH    = ram_depth(KERNEL_NUM_DEF);
  localparam int unsigned OUTPUT_POINT = output_point(KERNEL_NUM_DEF);
  localparam int unsigned START_ADDR   = (2 ** ENG_AW_DEF) - 2;
  localparam int unsigned DONE_ADDR    = (2 ** ENG_AW_DEF) - 1;

endpackage

// File: rtl/conv3_load_aligner.sv
// rtl/conv3_load_aligner.sv - one-stage pipeline lining up engine writes with source read data
module conv3_load_aligner #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          we_q;
  logic [AW-1:0] addr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q   <= i_we;
      addr_q <= i_addr;
    end
  end

  // Source data already arrives one cycle after the read strobe, so it passes straight through.
  assign o_we   = we_q;
  assign o_addr = we_q ? addr_q : '0;
  assign o_data = we_q ? i_data : '0;

endmodule

// File: rtl/conv3_tile_sequencer.sv
// rtl/conv3_tile_sequencer.sv - runs load/start/poll/readback on the convolution engine per tile
module conv3_tile_sequencer
  import conv3_pkg::*;
#(
  parameter int unsigned ENG_AW     = ENG_AW_DEF,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KERNEL_NUM = KERNEL_NUM_DEF,
  parameter int unsigned SRC_AW     = 16,
  parameter int unsigned DST_AW     = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [SRC_AW-1:0]     i_cmd_src_base,
  input  logic [DST_AW-1:0]     i_cmd_dst_base,
  input  logic [CNT_W-1:0]      i_cmd_count,
  output logic                  o_src_re,
  output logic [SRC_AW-1:0]     o_src_addr,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  output logic                  o_eng_we,
  output logic [ENG_AW-1:0]     o_eng_waddr,
  output logic [DATA_WIDTH-1:0] o_eng_wdata,
  output logic                  o_eng_re,
  output logic [ENG_AW-1:0]     o_eng_raddr,
  input  logic [DATA_WIDTH-1:0] i_eng_rdata,
  output logic                  o_dst_we,
  output logic [DST_AW-1:0]     o_dst_addr,
  output logic [DATA_WIDTH-1:0] o_dst_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [CNT_W-1:0]      o_tile_idx
);

  localparam int unsigned RAM_WORDS = ram_depth(KERNEL_NUM);
  localparam int unsigned OUT_WORDS = output_point(KERNEL_NUM);
  localparam int unsigned CNT_MAX   = (RAM_WORDS > TIMEOUT) ? RAM_WORDS : TIMEOUT;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);
  localparam logic [ENG_AW-1:0] ENG_START_ADDR = {{(ENG_AW-1){1'b1}}, 1'b0};
  localparam logic [ENG_AW-1:0] ENG_DONE_ADDR  = {ENG_AW{1'b1}};

  conv3_state_e        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    tile_q, tile_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SRC_AW-1:0]   src_ptr_q, src_ptr_d;
  logic [DST_AW-1:0]   dst_ptr_q, dst_ptr_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                start_we;
  logic                al_we;
  logic [ENG_AW-1:0]   al_addr;
  logic [DATA_WIDTH-1:0] al_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tile_q    <= '0;
      count_q   <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tile_q    <= tile_d;
      count_q   <= count_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Source and destination pointers run continuously across tiles, so tile*stride never needs a multiplier.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_d      = tile_q;
    count_d     = count_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    done_d      = 1'b0;
    error_d     = error_q;
    o_cmd_ready = 1'b0;
    o_src_re    = 1'b0;
    o_src_addr  = '0;
    start_we    = 1'b0;
    o_eng_re    = 1'b0;
    o_eng_raddr = '0;
    o_dst_we    = 1'b0;
    o_dst_addr  = '0;
    o_dst_data  = '0;

    case (state_q)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          src_ptr_d = i_cmd_src_base;
          dst_ptr_d = i_cmd_dst_base;
          count_d   = i_cmd_count;
          tile_d    = '0;
          cnt_d     = '0;
          error_d   = 1'b0;
          if (i_cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        o_src_re   = 1'b1;
        o_src_addr = src_ptr_q;
        src_ptr_d  = src_ptr_q + 1'b1;
        if (cnt_q == CW'(RAM_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DRAIN: state_d = ST_START;

      ST_START: begin
        start_we = 1'b1;
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        o_eng_re    = 1'b1;
        o_eng_raddr = ENG_DONE_ADDR;
        if (i_eng_rdata[0]) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_READ: begin
        o_eng_re    = 1'b1;
        o_eng_raddr = ENG_AW'(RAM_WORDS) + ENG_AW'(cnt_q);
        o_dst_we    = 1'b1;
        o_dst_addr  = dst_ptr_q;
        o_dst_data  = i_eng_rdata;
        dst_ptr_d   = dst_ptr_q + 1'b1;
        if (cnt_q == CW'(OUT_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_NEXT: begin
        if (tile_q + CNT_W'(1) == count_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tile_d  = tile_q + CNT_W'(1);
          state_d = ST_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  conv3_load_aligner #(
    .AW (ENG_AW),
    .DW (DATA_WIDTH)
  ) u_aligner (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (o_src_re),
    .i_addr  (ENG_AW'(cnt_q)),
    .i_data  (i_src_data),
    .o_we    (al_we),
    .o_addr  (al_addr),
    .o_data  (al_data)
  );

  // The aligner is always empty during START, so the two write sources never collide.
  assign o_eng_we    = al_we | start_we;
  assign o_eng_waddr = start_we ? ENG_START_ADDR : al_addr;
  assign o_eng_wdata = start_we ? DATA_WIDTH'(1) : al_data;

  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_tile_idx = tile_q;

endmodule

// File: tb/tb_conv3_tile_sequencer.sv
// tb/tb_conv3_tile_sequencer.sv - scoreboard bench with source memory and engine models
module tb_conv3_tile_sequencer;
  import conv3_pkg::*;

  localparam int TO = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [15:0] i_cmd_src_base = '0;
  logic [15:0] i_cmd_dst_base = '0;
  logic [7:0]  i_cmd_count = '0;
  logic        o_src_re;
  logic [15:0] o_src_addr;
  logic [31:0] i_src_data = '0;
  logic        o_eng_we;
  logic [13:0] o_eng_waddr;
  logic [31:0] o_eng_wdata;
  logic        o_eng_re;
  logic [13:0] o_eng_raddr;
  logic [31:0] i_eng_rdata;
  logic        o_dst_we;
  logic [15:0] o_dst_addr;
  logic [31:0] o_dst_data;
  logic        o_busy, o_done, o_error;
  logic [7:0]  o_tile_idx;

  always #5 i_clk = ~i_clk;

  conv3_tile_sequencer #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_src_base(i_cmd_src_base), .i_cmd_dst_base(i_cmd_dst_base), .i_cmd_count(i_cmd_count),
    .o_src_re(o_src_re), .o_src_addr(o_src_addr), .i_src_data(i_src_data),
    .o_eng_we(o_eng_we), .o_eng_waddr(o_eng_waddr), .o_eng_wdata(o_eng_wdata),
    .o_eng_re(o_eng_re), .o_eng_raddr(o_eng_raddr), .i_eng_rdata(i_eng_rdata),
    .o_dst_we(o_dst_we), .o_dst_addr(o_dst_addr), .o_dst_data(o_dst_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_tile_idx(o_tile_idx)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int poll_cnt = 0;
  bit mon_en = 1'b0;
  bit never_done = 1'b0;
  logic [63:0] q_src[$];
  logic [63:0] q_ew[$];
  logic [63:0] q_dw[$];
  bit          q_done[$];

  function automatic logic [31:0] src_val(input logic [15:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h expected no transfer", nm, act);
  endtask

  // Source memory: data valid one cycle after the strobe, garbage otherwise.
  always @(posedge i_clk) i_src_data <= o_src_re ? src_val(o_src_addr) : $urandom();

  // Engine: stores RAM writes, finishes a few cycles after START, DONE cleared by reading it.
  logic [31:0] eng_ram [0:RAM_DEPTH-1];
  logic [31:0] res0 = '0, res1 = '0;
  bit          eng_done = 1'b0, eng_run = 1'b0;
  int          eng_lat = 0;

  function automatic logic [31:0] eng_result(input bit second);
    logic [31:0] s0 = '0, s1 = '0;
    for (int w = 0; w < RAM_DEPTH; w++) begin
      s0 += eng_ram[w];
      s1 ^= eng_ram[w] + 32'(w);
    end
    return second ? s1 : s0;
  endfunction

  always @(posedge i_clk) begin
    if (o_eng_we && o_eng_waddr < RAM_DEPTH) eng_ram[o_eng_waddr] <= o_eng_wdata;
    if (o_eng_re && o_eng_raddr == DONE_ADDR) eng_done <= 1'b0;
    if (o_eng_we && o_eng_waddr == START_ADDR) begin
      eng_run <= 1'b1;
      eng_lat <= $urandom_range(1, 9);
    end else if (eng_run) begin
      if (eng_lat <= 1) begin
        eng_run <= 1'b0;
        if (!never_done) begin
          eng_done <= 1'b1;
          res0 <= eng_result(1'b0);
          res1 <= eng_result(1'b1);
        end
      end else begin
        eng_lat <= eng_lat - 1;
      end
    end
  end

  always_comb begin
    i_eng_rdata = '0;
    if (o_eng_raddr == DONE_ADDR) i_eng_rdata = {31'b0, eng_done};
    else if (o_eng_raddr == RAM_DEPTH) i_eng_rdata = res0;
    else if (o_eng_raddr == RAM_DEPTH + 1) i_eng_rdata = res1;
  end

  // Reference: every transfer a command should produce, derived from the tile arithmetic.
  task automatic expect_cmd(input logic [15:0] sb, input logic [15:0] db, input int cnt, input bit tmo);
    int ntile;
    logic [15:0] a;
    logic [31:0] v, s0, s1;
    ntile = tmo ? 1 : cnt;
    for (int t = 0; t < ntile; t++) begin
      s0 = '0;
      s1 = '0;
      for (int w = 0; w < RAM_DEPTH; w++) begin
        a = sb + 16'(t * RAM_DEPTH + w);
        v = src_val(a);
        q_src.push_back(64'({8'(t), a}));
        q_ew.push_back(64'({14'(w), v}));
        s0 += v;
        s1 ^= v + 32'(w);
      end
      q_ew.push_back(64'({14'(START_ADDR), 32'd1}));
      if (!tmo) begin
        q_dw.push_back(64'({db + 16'(t * OUTPUT_POINT), s0}));
        q_dw.push_back(64'({db + 16'(t * OUTPUT_POINT + 1), s1}));
      end
    end
    q_done.push_back(tmo);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_eng_we && o_eng_re) unexp("we_re_overlap", {o_eng_waddr, o_eng_raddr});
      if (o_src_re) begin
        if (q_src.size() == 0) unexp("src_read", {o_tile_idx, o_src_addr});
        else chk("src_read", {o_tile_idx, o_src_addr}, q_src.pop_front());
      end
      if (o_eng_we) begin
        if (q_ew.size() == 0) unexp("eng_write", {o_eng_waddr, o_eng_wdata});
        else chk("eng_write", {o_eng_waddr, o_eng_wdata}, q_ew.pop_front());
      end
      if (o_dst_we) begin
        if (q_dw.size() == 0) unexp("dst_write", {o_dst_addr, o_dst_data});
        else chk("dst_write", {o_dst_addr, o_dst_data}, q_dw.pop_front());
      end
      if (o_done) begin
        done_seen++;
        if (q_done.size() == 0) unexp("done_pulse", 64'(o_error));
        else chk("done_error", 64'(o_error), 64'(q_done.pop_front()));
      end
      if (o_eng_re && o_eng_raddr == DONE_ADDR) poll_cnt++;
    end
  end

  task automatic send_cmd(input logic [15:0] sb, input logic [15:0] db, input int cnt, input bit tmo);
    for (int i = 0; i < 100 && !o_cmd_ready; i++) @(negedge i_clk);
    chk("cmd_ready", 64'(o_cmd_ready), 64'd1);
    expect_cmd(sb, db, cnt, tmo);
    i_cmd_valid    = 1'b1;
    i_cmd_src_base = sb;
    i_cmd_dst_base = db;
    i_cmd_count    = 8'(cnt);
    @(negedge i_clk);
    i_cmd_valid    = 1'b0;
    i_cmd_src_base = 16'($urandom());
    i_cmd_dst_base = 16'($urandom());
    i_cmd_count    = 8'($urandom());
    chk("error_cleared", 64'(o_error), 64'd0);
    chk("busy_after_accept", 64'(o_busy), 64'(cnt != 0));
    if (cnt == 0) chk("zero_count_done", 64'(o_done), 64'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 5000 && done_seen < target; i++) @(negedge i_clk);
    chk("done_reached", 64'(done_seen >= target), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sb;
    int target;

    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", 64'(o_cmd_ready), 64'd1);
      chk("idle_busy", 64'(o_busy), 64'd0);
      chk("idle_strobes", 64'({o_src_re, o_eng_we, o_eng_re, o_dst_we, o_done, o_error}), 64'd0);
      chk("idle_tile", 64'(o_tile_idx), 64'd0);
      @(negedge i_clk);
    end

    send_cmd(16'h0100, 16'h0040, 1, 1'b0);
    wait_done(1);

    send_cmd(16'h0000, 16'h0000, 3, 1'b0);
    repeat (50) @(negedge i_clk);
    i_cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("ready_while_busy", 64'(o_cmd_ready), 64'd0);
    end
    i_cmd_valid = 1'b0;
    wait_done(2);

    send_cmd(16'($urandom()), 16'($urandom()), 0, 1'b0);
    wait_done(3);
    @(negedge i_clk);
    chk("zero_done_single", 64'(o_done), 64'd0);

    never_done = 1'b1;
    poll_cnt   = 0;
    send_cmd(16'($urandom()), 16'($urandom()), 2, 1'b1);
    wait_done(4);
    chk("timeout_polls", 64'(poll_cnt), 64'(TO));
    chk("error_sticky", 64'(o_error), 64'd1);
    never_done = 1'b0;
    repeat (3) @(negedge i_clk);
    send_cmd(16'($urandom()), 16'($urandom()), 1, 1'b0);
    wait_done(5);

    sb = 16'($urandom());
    send_cmd(sb, 16'($urandom()), 2, 1'b0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
        if (o_src_re && o_src_addr == sb + 16'd100) begin
          hit = 1'b1;
          i_rst_n = 1'b0;
        end else begin
          @(negedge i_clk);
        end
      end
      chk("reset_point_found", 64'(hit), 64'd1);
    end
    @(negedge i_clk);
    q_src.delete();
    q_ew.delete();
    q_dw.delete();
    q_done.delete();
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_strobes", 64'({o_src_re, o_eng_we, o_eng_re, o_dst_we, o_done}), 64'd0);
    i_rst_n = 1'b1;
    send_cmd(16'($urandom()), 16'($urandom()), 1, 1'b0);
    wait_done(6);

    target = 6;
    for (int k = 0; k < 4; k++) begin
      target++;
      if (k == 0) send_cmd(16'hFE80, 16'hFFFF, 2, 1'b0);
      else send_cmd(16'($urandom()), 16'($urandom()), $urandom_range(1, 3), 1'b0);
      wait_done(target);
    end

    repeat (5) @(negedge i_clk);
    chk("src_left", 64'(q_src.size()), 64'd0);
    chk("eng_left", 64'(q_ew.size()), 64'd0);
    chk("dst_left", 64'(q_dw.size()), 64'd0);
    chk("done_left", 64'(q_done.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
